// File: rtl/stopwatch_pkg.sv
// Shared definitions for the stopwatch display path.
// Provides the arbiter state encoding, the source codes reported on the
// display source output, the default timing constants (in milliseconds at
// the 1 kHz scan clock) and a helper that maps a state to its source code.
package stopwatch_pkg;

  typedef enum logic [1:0] {
    ST_LIVE  = 2'd0,
    ST_LAP   = 2'd1,
    ST_ALERT = 2'd2
  } state_t;

  localparam logic [1:0] SRC_LIVE  = 2'd0;
  localparam logic [1:0] SRC_LAP   = 2'd1;
  localparam logic [1:0] SRC_ALERT = 2'd2;

  localparam int HOLD_MS       = 3000;
  localparam int BLINK_HALF    = 250;
  localparam int ALERT_FLASHES = 4;
  localparam int TW            = 12;

  function automatic logic [1:0] src_of(state_t st);
    logic [1:0] code;
    code = SRC_LIVE;
    case (st)
      ST_LAP:   code = SRC_LAP;
      ST_ALERT: code = SRC_ALERT;
      default:  code = SRC_LIVE;
    endcase
    return code;
  endfunction

endpackage

// File: rtl/display_arbiter_if.sv
// Bundle between the stopwatch counter/lap logic and the display arbiter.
//   live_*          : running time (hours, minutes, seconds, centiseconds)
//   lap_req, lap_*  : single-cycle lap recall request and its snapshot values
//   alert_req       : single-cycle alert request
//   lap_ack/alert_ack : single-cycle acknowledges from the arbiter
//   disp_*, blank   : values and digit gating for the display driver
//   src, busy       : current display source (0 live, 1 lap, 2 alert)
// master = requester side, slave = arbiter side.
interface display_arbiter_if;

  logic [7:0] live_h, live_m, live_s, live_c;
  logic       lap_req;
  logic [7:0] lap_h, lap_m, lap_s, lap_c;
  logic       lap_ack;
  logic       alert_req;
  logic       alert_ack;
  logic [7:0] disp_h, disp_m, disp_s, disp_c;
  logic       blank;
  logic [1:0] src;
  logic       busy;

  modport master (
    output live_h, live_m, live_s, live_c,
    output lap_req, lap_h, lap_m, lap_s, lap_c,
    output alert_req,
    input  lap_ack, alert_ack,
    input  disp_h, disp_m, disp_s, disp_c,
    input  blank, src, busy
  );

  modport slave (
    input  live_h, live_m, live_s, live_c,
    input  lap_req, lap_h, lap_m, lap_s, lap_c,
    input  alert_req,
    output lap_ack, alert_ack,
    output disp_h, disp_m, disp_s, disp_c,
    output blank, src, busy
  );

endinterface

// File: rtl/ms_down_counter.sv
// Millisecond down-counter used for the lap hold / alert duration timer and
// for the blink half-period timer.
//   clk_scan, rst : 1 kHz scan clock, asynchronous active-high reset
//   load, load_val: load a new count (wins over decrement)
//   en            : decrement by one per cycle; the count sticks at zero
//   zero          : count currently reads zero
module ms_down_counter #(
  parameter int TW = 12
) (
  input  logic          clk_scan,
  input  logic          rst,
  input  logic          load,
  input  logic [TW-1:0] load_val,
  input  logic          en,
  output logic          zero
);

  logic [TW-1:0] count_q;

  // NOTE: clocked state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk_scan or posedge rst) begin
    if (rst) begin
      count_q <= '0;
    end else if (load) begin
      count_q <= load_val;
    end else if (en && (count_q != '0)) begin
      count_q <= count_q - TW'(1);
    end
  end

  assign zero = (count_q == '0);

endmodule

// File: rtl/display_arbiter.sv
// Display arbiter: chooses what the 8-digit multiplexed display shows.
//   clk_scan : 1 kHz scan clock (one cycle = 1 ms)
//   rst      : asynchronous active-high reset
//   bus      : display_arbiter_if.slave -- live time, lap/alert requests and
//              acks, registered display values, blank, src and busy
// Priority is alert > lap > live. A lap snapshot is held for HOLD_MS cycles;
// an alert blinks the live time for 2*BLINK_HALF*ALERT_FLASHES cycles,
// starting with the digits lit, and always returns to live afterwards.
module display_arbiter #(
  parameter int HOLD_MS       = stopwatch_pkg::HOLD_MS,
  parameter int BLINK_HALF    = stopwatch_pkg::BLINK_HALF,
  parameter int ALERT_FLASHES = stopwatch_pkg::ALERT_FLASHES,
  parameter int TW            = stopwatch_pkg::TW
) (
  input  logic                clk_scan,
  input  logic                rst,
  display_arbiter_if.slave    bus
);

  import stopwatch_pkg::*;

  localparam logic [TW-1:0] HOLD_LOAD  = TW'(HOLD_MS - 1);
  localparam logic [TW-1:0] ALERT_LOAD = TW'(2 * BLINK_HALF * ALERT_FLASHES - 1);
  localparam logic [TW-1:0] BLINK_LOAD = TW'(BLINK_HALF - 1);

  state_t        state_q, state_d;
  logic          dur_load, dur_zero;
  logic [TW-1:0] dur_val;
  logic          blink_load, blink_zero, blink_wrap;
  logic          lap_take, alert_take;
  logic          blank_d;

  // One timer serves both the lap hold and the alert duration, since the two
  // states are mutually exclusive and either entry reloads it.
  ms_down_counter #(.TW(TW)) u_dur_timer (
    .clk_scan (clk_scan),
    .rst      (rst),
    .load     (dur_load),
    .load_val (dur_val),
    .en       (state_q != ST_LIVE),
    .zero     (dur_zero)
  );

  ms_down_counter #(.TW(TW)) u_blink_timer (
    .clk_scan (clk_scan),
    .rst      (rst),
    .load     (blink_load),
    .load_val (BLINK_LOAD),
    .en       (state_q == ST_ALERT),
    .zero     (blink_zero)
  );

  always_ff @(posedge clk_scan or posedge rst) begin
    if (rst) state_q <= ST_LIVE;
    else     state_q <= state_d;
  end

  // NOTE: every signal driven here gets a default first, so no path through
  // the block leaves a value unassigned and no latch is inferred.
  always_comb begin
    state_d    = state_q;
    dur_load   = 1'b0;
    dur_val    = HOLD_LOAD;
    lap_take   = 1'b0;
    alert_take = 1'b0;
    blink_wrap = 1'b0;
    blank_d    = 1'b0;

    if (bus.alert_req) begin
      // Alert wins any simultaneous lap request and restarts an active alert.
      state_d    = ST_ALERT;
      alert_take = 1'b1;
      dur_load   = 1'b1;
      dur_val    = ALERT_LOAD;
    end else if (bus.lap_req && (state_q != ST_ALERT)) begin
      state_d  = ST_LAP;
      lap_take = 1'b1;
      dur_load = 1'b1;
      dur_val  = HOLD_LOAD;
    end else if ((state_q != ST_LIVE) && dur_zero) begin
      state_d = ST_LIVE;
    end

    // Half-period wrap: reload the blink timer and flip the digit gating.
    if ((state_q == ST_ALERT) && blink_zero && !alert_take) begin
      blink_wrap = 1'b1;
    end

    if ((state_d == ST_ALERT) && !alert_take) begin
      blank_d = blink_wrap ? ~bus.blank : bus.blank;
    end
  end

  assign blink_load = alert_take || blink_wrap;

  always_ff @(posedge clk_scan or posedge rst) begin
    if (rst) begin
      bus.disp_h    <= '0;
      bus.disp_m    <= '0;
      bus.disp_s    <= '0;
      bus.disp_c    <= '0;
      bus.blank     <= 1'b0;
      bus.src       <= SRC_LIVE;
      bus.busy      <= 1'b0;
      bus.lap_ack   <= 1'b0;
      bus.alert_ack <= 1'b0;
    end else begin
      bus.lap_ack   <= lap_take;
      bus.alert_ack <= alert_take;
      bus.blank     <= blank_d;
      bus.src       <= src_of(state_d);
      bus.busy      <= (state_d != ST_LIVE);
      if (state_d == ST_LAP) begin
        // The snapshot is only captured in the accepting cycle, then frozen.
        if (lap_take) begin
          bus.disp_h <= bus.lap_h;
          bus.disp_m <= bus.lap_m;
          bus.disp_s <= bus.lap_s;
          bus.disp_c <= bus.lap_c;
        end
      end else begin
        bus.disp_h <= bus.live_h;
        bus.disp_m <= bus.live_m;
        bus.disp_s <= bus.live_s;
        bus.disp_c <= bus.live_c;
      end
    end
  end

endmodule
